// File: rtl/bird_launch_controller_pkg.sv
// Shared definitions for the bird launch sequencer.
//   launch_state_t : 3-bit state code, also driven out as launch_state
//   DEF_*          : defaults for the top-level parameters
//   FRAME_CNT_W    : width of the shared frame counter
package bird_launch_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AIM    = 3'd1,
    S_CHARGE = 3'd2,
    S_FLIGHT = 3'd3,
    S_RELOAD = 3'd4
  } launch_state_t;

  localparam int DEF_ANGLE_MAX = 7;
  localparam int DEF_MAX_POWER = 15;
  localparam int FRAME_CNT_W   = 7;

endpackage

// File: rtl/bird_launch_controller_frame_tick_counter.sv
// Frame counter shared by the CHARGE, FLIGHT and RELOAD phases.
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous clear, wins over tick
//   tick       : startOfFrame pulse
//   tc         : terminal count for the current phase
//   done       : this tick is the tc-th frame since the last clear
// The count saturates instead of wrapping.
module frame_tick_counter
  import bird_launch_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   tick,
  input  logic [FRAME_CNT_W-1:0] tc,
  output logic                   done
);

  localparam logic [FRAME_CNT_W-1:0] ONE = FRAME_CNT_W'(1);

  logic [FRAME_CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                       count_d = '0;
    else if (tick && count_q != '1) count_d = count_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Done fires on the frame that would take the count to tc.
  assign done = tick && (count_q == tc - ONE);

endmodule

// File: rtl/bird_launch_controller.sv
// Bird launch sequencer: aim -> charge -> launch -> flight -> reload.
//   clk, reset      : clock, synchronous active-high reset
//   startOfFrame    : frame pulse; every timing count advances on it
//   startGame       : level, game in play (low forces IDLE)
//   newLevelPulse   : forces AIM with default angle and zero power
//   birds_left      : remaining birds from the game controller
//   shoot_key       : press starts charge, release fires
//   angle_up_key /
//   angle_down_key  : rising edges step the angle
//   collisionBird   : flying bird hit something
//   shoot_bird_pulse: one-cycle launch strobe
//   launch_power, launch_angle, bird_active, bird_on_sling, launch_state:
//                     registered status to motion block and HUD
module bird_launch_controller
  import bird_launch_controller_pkg::*;
#(
  parameter int MAX_POWER      = DEF_MAX_POWER,
  parameter int CHARGE_FRAMES  = 2,
  parameter int FLIGHT_TIMEOUT = 90,
  parameter int RELOAD_FRAMES  = 15,
  parameter int ANGLE_MAX      = DEF_ANGLE_MAX,
  parameter int ANGLE_DEFAULT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       startGame,
  input  logic       newLevelPulse,
  input  logic [3:0] birds_left,
  input  logic       shoot_key,
  input  logic       angle_up_key,
  input  logic       angle_down_key,
  input  logic       collisionBird,
  output logic       shoot_bird_pulse,
  output logic [3:0] launch_power,
  output logic [2:0] launch_angle,
  output logic       bird_active,
  output logic       bird_on_sling,
  output logic [2:0] launch_state
);

  localparam logic [3:0] PWR_MAX = 4'(MAX_POWER);
  localparam logic [2:0] ANG_MAX = 3'(ANGLE_MAX);
  localparam logic [2:0] ANG_DEF = 3'(ANGLE_DEFAULT);

  launch_state_t state_q, state_d;
  logic [3:0]    power_q, power_d;
  logic [2:0]    angle_q, angle_d;
  logic          pulse_q, pulse_d;
  logic          active_q, active_d;
  logic          sling_q, sling_d;
  logic          shoot_prev_q, shoot_prev_d;
  logic          up_prev_q, up_prev_d;
  logic          down_prev_q, down_prev_d;

  logic                   shoot_edge, up_edge, down_edge;
  logic                   chg_step, cnt_clr, cnt_done;
  logic [FRAME_CNT_W-1:0] cnt_tc;

  assign shoot_edge = shoot_key      && !shoot_prev_q;
  assign up_edge    = angle_up_key   && !up_prev_q;
  assign down_edge  = angle_down_key && !down_prev_q;

  // Edge-detect history tracks the keys every cycle regardless of state,
  // so a shoot_key held across RELOAD never looks like a fresh press.
  assign shoot_prev_d = shoot_key;
  assign up_prev_d    = angle_up_key;
  assign down_prev_d  = angle_down_key;

  always_comb begin
    cnt_tc = FRAME_CNT_W'(FLIGHT_TIMEOUT);
    unique case (state_q)
      S_CHARGE: cnt_tc = FRAME_CNT_W'(CHARGE_FRAMES);
      S_RELOAD: cnt_tc = FRAME_CNT_W'(RELOAD_FRAMES);
      default:  cnt_tc = FRAME_CNT_W'(FLIGHT_TIMEOUT);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    power_d  = power_q;
    angle_d  = angle_q;
    pulse_d  = 1'b0;
    chg_step = 1'b0;
    if (!startGame) begin
      state_d = S_IDLE;
      power_d = '0;
      angle_d = ANG_DEF;
    end else if (newLevelPulse) begin
      state_d = S_AIM;
      power_d = '0;
      angle_d = ANG_DEF;
    end else begin
      unique case (state_q)
        S_IDLE: if (birds_left != '0) state_d = S_AIM;
        S_AIM: begin
          if (up_edge && !down_edge && angle_q < ANG_MAX)
            angle_d = angle_q + 3'd1;
          else if (down_edge && !up_edge && angle_q != '0)
            angle_d = angle_q - 3'd1;
          if (shoot_edge) begin
            state_d = S_CHARGE;
            power_d = 4'd1;
          end
        end
        S_CHARGE: begin
          // Release beats a same-cycle power step.
          if (!shoot_key) begin
            state_d = S_FLIGHT;
            pulse_d = 1'b1;
          end else if (cnt_done) begin
            chg_step = 1'b1;
            if (power_q < PWR_MAX) power_d = power_q + 4'd1;
          end
        end
        S_FLIGHT: begin
          if (collisionBird || cnt_done) begin
            state_d = S_RELOAD;
            power_d = '0;
          end
        end
        S_RELOAD: if (cnt_done) state_d = (birds_left != '0) ? S_AIM : S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
    active_d = (state_d == S_FLIGHT);
    sling_d  = (state_d == S_AIM) || (state_d == S_CHARGE);
  end

  // Counter idles cleared outside the timed states and restarts on every
  // state change and every charge step.
  assign cnt_clr = chg_step || (state_d != state_q) ||
                   (state_q == S_IDLE) || (state_q == S_AIM);

  frame_tick_counter u_frame_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .tick (startOfFrame),
    .tc   (cnt_tc),
    .done (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      power_q      <= '0;
      angle_q      <= ANG_DEF;
      pulse_q      <= 1'b0;
      active_q     <= 1'b0;
      sling_q      <= 1'b0;
      shoot_prev_q <= 1'b0;
      up_prev_q    <= 1'b0;
      down_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      power_q      <= power_d;
      angle_q      <= angle_d;
      pulse_q      <= pulse_d;
      active_q     <= active_d;
      sling_q      <= sling_d;
      shoot_prev_q <= shoot_prev_d;
      up_prev_q    <= up_prev_d;
      down_prev_q  <= down_prev_d;
    end
  end

  assign shoot_bird_pulse = pulse_q;
  assign launch_power     = power_q;
  assign launch_angle     = angle_q;
  assign bird_active      = active_q;
  assign bird_on_sling    = sling_q;
  assign launch_state     = state_q;

endmodule

// File: tb/tb_bird_launch_controller.sv
module tb_bird_launch_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       startGame = 1'b0;
  logic       newLevelPulse = 1'b0;
  logic [3:0] birds_left = 4'd0;
  logic       shoot_key = 1'b0;
  logic       angle_up_key = 1'b0;
  logic       angle_down_key = 1'b0;
  logic       collisionBird = 1'b0;
  logic       shoot_bird_pulse;
  logic [3:0] launch_power;
  logic [2:0] launch_angle;
  logic       bird_active;
  logic       bird_on_sling;
  logic [2:0] launch_state;

  bird_launch_controller dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .startGame(startGame),
    .newLevelPulse(newLevelPulse), .birds_left(birds_left), .shoot_key(shoot_key),
    .angle_up_key(angle_up_key), .angle_down_key(angle_down_key),
    .collisionBird(collisionBird), .shoot_bird_pulse(shoot_bird_pulse),
    .launch_power(launch_power), .launch_angle(launch_angle),
    .bird_active(bird_active), .bird_on_sling(bird_on_sling),
    .launch_state(launch_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pulse;
    logic [3:0] pw;
    logic [2:0] ang;
    logic       act;
    logic       sling;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done_flag = 1'b0;

  // Reference model: phases 0 idle,1 aim,2 charge,3 flight,4 reload.
  // Time is tracked as total frames spent in the current phase.
  int m_phase = 0, m_angle = 3, m_power = 0, m_frames = 0, m_pulse = 0;
  int m_ps = 0, m_pu = 0, m_pd = 0;

  task automatic model_step();
    int up_e, dn_e, sh_e;
    if (reset) begin
      m_phase = 0; m_angle = 3; m_power = 0; m_frames = 0; m_pulse = 0;
      m_ps = 0; m_pu = 0; m_pd = 0;
      return;
    end
    up_e = (angle_up_key && !m_pu) ? 1 : 0;
    dn_e = (angle_down_key && !m_pd) ? 1 : 0;
    sh_e = (shoot_key && !m_ps) ? 1 : 0;
    m_pulse = 0;
    if (!startGame) begin
      m_phase = 0; m_power = 0; m_angle = 3; m_frames = 0;
    end else if (newLevelPulse) begin
      m_phase = 1; m_power = 0; m_angle = 3; m_frames = 0;
    end else begin
      case (m_phase)
        0: if (birds_left != 0) begin m_phase = 1; m_frames = 0; end
        1: begin
          if (up_e && !dn_e) m_angle = (m_angle < 7) ? m_angle + 1 : 7;
          else if (dn_e && !up_e) m_angle = (m_angle > 0) ? m_angle - 1 : 0;
          if (sh_e) begin m_phase = 2; m_power = 1; m_frames = 0; end
        end
        2: begin
          if (!shoot_key) begin
            m_phase = 3; m_pulse = 1; m_frames = 0;
          end else if (startOfFrame) begin
            m_frames++;
            m_power = 1 + m_frames / 2;
            if (m_power > 15) m_power = 15;
          end
        end
        3: begin
          if (startOfFrame) m_frames++;
          if (collisionBird || m_frames == 90) begin
            m_phase = 4; m_power = 0; m_frames = 0;
          end
        end
        default: begin
          if (startOfFrame) m_frames++;
          if (m_frames == 15) begin
            m_phase = (birds_left != 0) ? 1 : 0; m_frames = 0;
          end
        end
      endcase
    end
    m_ps = shoot_key; m_pu = angle_up_key; m_pd = angle_down_key;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.st    = 3'(m_phase);
    o.pulse = (m_pulse != 0);
    o.pw    = 4'(m_power);
    o.ang   = 3'(m_angle);
    o.act   = (m_phase == 3);
    o.sling = (m_phase == 1 || m_phase == 2);
    return o;
  endfunction

  // One clock: predict the post-edge outputs, queue them, then advance.
  task automatic cyc();
    model_step();
    exp_q.push_back(model_obs());
    @(posedge clk); #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1; cyc();
    startOfFrame = 1'b0; cyc(); cyc();
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic tap_up();
    angle_up_key = 1'b1; cyc(); angle_up_key = 1'b0; cyc();
  endtask

  task automatic tap_dn();
    angle_down_key = 1'b1; cyc(); angle_down_key = 1'b0; cyc();
  endtask

  // Monitor: the DUT presents a full output set every clock.
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a.st = launch_state; a.pulse = shoot_bird_pulse; a.pw = launch_power;
      a.ang = launch_angle; a.act = bird_active; a.sling = bird_on_sling;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t got st=%0d pulse=%0b pw=%0d ang=%0d act=%0b sling=%0b want st=%0d pulse=%0b pw=%0d ang=%0d act=%0b sling=%0b",
                 $time, a.st, a.pulse, a.pw, a.ang, a.act, a.sling,
                 e.st, e.pulse, e.pw, e.ang, e.act, e.sling);
      end
    end
  end

  initial begin
    #2000000;
    if (!done_flag) begin
      failures++;
      $display("FAIL timeout: stimulus did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    reset = 1'b1; cyc(); cyc();
    checks++;
    if (launch_state !== 3'd0 || shoot_bird_pulse !== 1'b0 || launch_power !== 4'd0 ||
        launch_angle !== 3'd3 || bird_active !== 1'b0 || bird_on_sling !== 1'b0) begin
      failures++;
      $display("FAIL reset state st=%0d pulse=%0b pw=%0d ang=%0d act=%0b sling=%0b",
               launch_state, shoot_bird_pulse, launch_power, launch_angle,
               bird_active, bird_on_sling);
    end
    reset = 1'b0; cyc();
    startGame = 1'b1; birds_left = 4'd10; cyc(); cyc();
    // Angle stepping and saturation.
    repeat (3) tap_up();
    repeat (5) tap_dn();
    angle_up_key = 1'b1; angle_down_key = 1'b1; cyc();
    angle_up_key = 1'b0; angle_down_key = 1'b0; cyc();
    repeat (7) tap_up();
    tap_dn();
    // Charge 7 frames, release, full timeout flight, reload.
    shoot_key = 1'b1; cyc(); frames(7);
    shoot_key = 1'b0; cyc(); cyc();
    frames(95);
    frames(12);
    // Long charge saturates, collision ends flight early.
    shoot_key = 1'b1; cyc(); frames(40);
    shoot_key = 1'b0; cyc();
    frames(10);
    collisionBird = 1'b1; cyc(); collisionBird = 1'b0;
    // Out of birds during reload, key held into the next aim.
    shoot_key = 1'b1; birds_left = 4'd0; frames(16);
    birds_left = 4'd5; cyc(); cyc(); frames(2);
    // Fresh press, charge to 5, new level aborts the shot.
    shoot_key = 1'b0; cyc(); shoot_key = 1'b1; cyc(); frames(8);
    newLevelPulse = 1'b1; cyc(); newLevelPulse = 1'b0; cyc();
    // Game ends mid-flight.
    shoot_key = 1'b0; cyc(); shoot_key = 1'b1; cyc(); frames(1);
    shoot_key = 1'b0; cyc(); frames(3);
    startGame = 1'b0; cyc();
    startGame = 1'b1; birds_left = 4'd3; cyc(); cyc();
    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      startOfFrame   = ($urandom_range(0, 2) == 0);
      startGame      = ($urandom_range(0, 599) != 0);
      newLevelPulse  = ($urandom_range(0, 399) == 0);
      collisionBird  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) shoot_key = ~shoot_key;
      if ($urandom_range(0, 7) == 0) angle_up_key = ~angle_up_key;
      if ($urandom_range(0, 7) == 0) angle_down_key = ~angle_down_key;
      if ($urandom_range(0, 99) == 0)
        birds_left = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 999) == 0) reset = 1'b1; else reset = 1'b0;
      cyc();
    end
    reset = 1'b0;
    cyc();
    @(negedge clk); #1;
    done_flag = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
